// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-stage program-counter sequencer.
// Holds the sequencing-op encodings and the top-level FSM state type.
package pc_seq_pkg;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JZ   = 3'd2;
  localparam logic [2:0] OP_JNZ  = 3'd3;
  localparam logic [2:0] OP_JC   = 3'd4;
  localparam logic [2:0] OP_CALL = 3'd5;
  localparam logic [2:0] OP_RET  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for the PC sequencer. Only pointer and count are reset;
// pushing when full wraps the pointer and overwrites the oldest entry.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset_ext,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [DW-1:0]           i_data,
  output logic [DW-1:0]           o_data,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, top_ptr;
  logic [CW-1:0] cnt_q, cnt_d;

  // ptr_q addresses the next free slot; the top of stack sits one below it.
  assign top_ptr = ptr_q - PW'(1);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (i_push) begin
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != FullCnt) cnt_d = cnt_q + CW'(1);
    end else if (i_pop) begin
      ptr_d = top_ptr;
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_ext) begin
    if (!i_reset_ext) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[ptr_q] <= i_data;
  end

  assign o_data  = mem_q[top_ptr];
  assign o_count = cnt_q;
  assign o_full  = (cnt_q == FullCnt);
  assign o_empty = (cnt_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: branches on Z/C, call/return stack, stall, halt/fault.
// Define PC_SEQ_STACK_CHECK_EN to trap stack overflow/underflow into FAULT.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned    AW           = 16,
  parameter int unsigned    STACK_DEPTH  = 4,
  parameter logic [AW-1:0]  RESET_VECTOR = '0
) (
  input  logic                          i_clk,
  input  logic                          i_reset_ext,
  input  logic                          i_stall,
  input  logic [2:0]                    i_op,
  input  logic [AW-1:0]                 i_target,
  input  logic                          i_alu_z,
  input  logic                          i_alu_c,
  output logic [AW-1:0]                 o_pm_addr,
  output logic [$clog2(STACK_DEPTH):0]  o_sp,
  output logic                          o_halted,
  output logic                          o_fault
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pc_inc;
  logic          push, pop;
  logic [AW-1:0] stack_top;
  logic          stack_full, stack_empty;

  assign pc_inc = pc_q + AW'(1);

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .DW    (AW)
  ) u_ret_stack (
    .i_clk       (i_clk),
    .i_reset_ext (i_reset_ext),
    .i_push      (push),
    .i_pop       (pop),
    .i_data      (pc_inc),
    .o_data      (stack_top),
    .o_count     (o_sp),
    .o_full      (stack_full),
    .o_empty     (stack_empty)
  );

  always_ff @(posedge i_clk or negedge i_reset_ext) begin
    if (!i_reset_ext) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (state_q == ST_RUN && !i_stall) begin
      unique case (i_op)
        OP_NEXT: pc_d = pc_inc;
        OP_JMP:  pc_d = i_target;
        OP_JZ:   pc_d = i_alu_z ? i_target : pc_inc;
        OP_JNZ:  pc_d = i_alu_z ? pc_inc : i_target;
        OP_JC:   pc_d = i_alu_c ? i_target : pc_inc;
        OP_CALL: begin
`ifdef PC_SEQ_STACK_CHECK_EN
          if (stack_full) begin
            state_d = ST_FAULT;
          end else begin
            push = 1'b1;
            pc_d = i_target;
          end
`else
          push = 1'b1;
          pc_d = i_target;
`endif
        end
        OP_RET: begin
`ifdef PC_SEQ_STACK_CHECK_EN
          if (stack_empty) begin
            state_d = ST_FAULT;
          end else begin
            pop  = 1'b1;
            pc_d = stack_top;
          end
`else
          pop  = 1'b1;
          pc_d = stack_top;
`endif
        end
        OP_HALT: state_d = ST_HALTED;
        default: pc_d = pc_q;
      endcase
    end
  end

  always_comb begin
    o_pm_addr = pc_q;
    o_halted  = (state_q == ST_HALTED);
`ifdef PC_SEQ_STACK_CHECK_EN
    o_fault   = (state_q == ST_FAULT);
`else
    o_fault   = 1'b0;
`endif
  end

`ifndef PC_SEQ_STACK_CHECK_EN
  // Occupancy flags only feed the fault checks.
  logic unused_stack_flags;
  assign unused_stack_flags = stack_full ^ stack_empty;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer against a queue-based model.
// Honours PC_SEQ_STACK_CHECK_EN the same way as the design.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int DEPTH = 4;

  logic        i_clk;
  logic        i_reset_ext;
  logic        i_stall;
  logic [2:0]  i_op;
  logic [15:0] i_target;
  logic        i_alu_z;
  logic        i_alu_c;
  logic [15:0] o_pm_addr;
  logic [2:0]  o_sp;
  logic        o_halted;
  logic        o_fault;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: PC value, return addresses as a queue, halt/fault flags.
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  bit          m_halted;
  bit          m_fault;

`ifdef PC_SEQ_STACK_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  pc_sequencer #(
    .AW           (16),
    .STACK_DEPTH  (DEPTH),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_ext (i_reset_ext),
    .i_stall     (i_stall),
    .i_op        (i_op),
    .i_target    (i_target),
    .i_alu_z     (i_alu_z),
    .i_alu_c     (i_alu_c),
    .o_pm_addr   (o_pm_addr),
    .o_sp        (o_sp),
    .o_halted    (o_halted),
    .o_fault     (o_fault)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    m_pc = 16'h0000;
    m_stack.delete();
    m_halted = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] op, input logic [15:0] tgt,
                            input logic z, input logic c, input logic stall);
    logic [15:0] nxt;
    nxt = m_pc + 16'd1;
    if (m_halted || m_fault || stall) return;
    case (op)
      OP_NEXT: m_pc = nxt;
      OP_JMP:  m_pc = tgt;
      OP_JZ:   m_pc = z ? tgt : nxt;
      OP_JNZ:  m_pc = !z ? tgt : nxt;
      OP_JC:   m_pc = c ? tgt : nxt;
      OP_CALL: begin
        if (CHECK && m_stack.size() == DEPTH) begin
          m_fault = 1'b1;
        end else begin
          m_stack.push_back(nxt);
          if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
          m_pc = tgt;
        end
      end
      OP_RET: begin
        if (m_stack.size() == 0) begin
          if (CHECK) m_fault = 1'b1;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end
      default: m_halted = 1'b1;
    endcase
  endtask

  // Drive one op before a rising edge, update the model, return at the falling edge.
  task automatic cycle(input logic [2:0] op, input logic [15:0] tgt,
                       input logic z, input logic c, input logic stall);
    i_op = op;
    i_target = tgt;
    i_alu_z = z;
    i_alu_c = c;
    i_stall = stall;
    @(posedge i_clk);
    model_step(op, tgt, z, c, stall);
    @(negedge i_clk);
  endtask

  task automatic apply_reset();
    i_reset_ext = 1'b0;
    #1;
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_op = OP_NEXT;
    i_stall = 1'b0;
    i_reset_ext = 1'b1;
  endtask

  task automatic test_reset();
    i_stall = 1'b0;
    i_op = OP_NEXT;
    i_target = '0;
    i_alu_z = 1'b0;
    i_alu_c = 1'b0;
    i_reset_ext = 1'b0;
    model_reset();
    @(negedge i_clk);
    n_cmp++;
    if (o_pm_addr !== 16'h0000) begin
      n_err++; $display("FAIL reset_pc: got %h expected 0000", o_pm_addr);
    end
    n_cmp++;
    if (o_sp !== 3'd0) begin
      n_err++; $display("FAIL reset_sp: got %0d expected 0", o_sp);
    end
    n_cmp++;
    if (o_halted !== 1'b0 || o_fault !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: got h=%b f=%b expected 0 0", o_halted, o_fault);
    end
    @(negedge i_clk);
    i_reset_ext = 1'b1;
  endtask

  task automatic test_next();
    for (int i = 0; i < 4; i++) begin
      cycle(OP_NEXT, 16'h0000, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (o_pm_addr !== 16'(i + 1)) begin
        n_err++; $display("FAIL next_seq[%0d]: got %h expected %h", i, o_pm_addr, 16'(i + 1));
      end
    end
  endtask

  task automatic test_cond_branch();
    logic [2:0] ops [6];
    logic       zs  [6];
    logic       cs  [6];
    logic       tk  [6];
    logic [15:0] exp_pc;
    ops = '{OP_JZ, OP_JZ, OP_JNZ, OP_JNZ, OP_JC, OP_JC};
    zs  = '{1'b1,  1'b0,  1'b0,   1'b1,   1'b0,  1'b1};
    cs  = '{1'b0,  1'b1,  1'b1,   1'b0,   1'b1,  1'b0};
    tk  = '{1'b1,  1'b0,  1'b1,   1'b0,   1'b1,  1'b0};
    for (int i = 0; i < 6; i++) begin
      cycle(OP_JMP, 16'h0020, 1'b0, 1'b0, 1'b0);
      cycle(ops[i], 16'h0040, zs[i], cs[i], 1'b0);
      exp_pc = tk[i] ? 16'h0040 : 16'h0021;
      n_cmp++;
      if (o_pm_addr !== exp_pc) begin
        n_err++; $display("FAIL cond_branch[%0d]: got %h expected %h", i, o_pm_addr, exp_pc);
      end
    end
  endtask

  task automatic test_call_ret();
    logic [2:0]  ops [5];
    logic [15:0] tg  [5];
    logic [15:0] epc [5];
    logic [2:0]  esp [5];
    ops = '{OP_CALL,  OP_NEXT,  OP_CALL,  OP_RET,   OP_RET};
    tg  = '{16'h0100, 16'h0000, 16'h0200, 16'h0000, 16'h0000};
    epc = '{16'h0100, 16'h0101, 16'h0200, 16'h0102, 16'h0011};
    esp = '{3'd1,     3'd1,     3'd2,     3'd1,     3'd0};
    cycle(OP_JMP, 16'h0010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(ops[i], tg[i], 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (o_pm_addr !== epc[i] || o_sp !== esp[i]) begin
        n_err++;
        $display("FAIL call_ret[%0d]: got pc=%h sp=%0d expected pc=%h sp=%0d",
                 i, o_pm_addr, o_sp, epc[i], esp[i]);
      end
    end
  endtask

  task automatic test_stack_full();
    cycle(OP_JMP, 16'h0030, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) cycle(OP_CALL, 16'(k * 256), 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_sp !== 3'd4) begin
      n_err++; $display("FAIL full_sp: got %0d expected 4", o_sp);
    end
`ifdef PC_SEQ_STACK_CHECK_EN
    n_cmp++;
    if (o_fault !== 1'b1 || o_pm_addr !== 16'h0400) begin
      n_err++;
      $display("FAIL full_fault: got f=%b pc=%h expected f=1 pc=0400", o_fault, o_pm_addr);
    end
    apply_reset();
`else
    n_cmp++;
    if (o_pm_addr !== 16'h0500 || o_fault !== 1'b0) begin
      n_err++;
      $display("FAIL full_wrap: got f=%b pc=%h expected f=0 pc=0500", o_fault, o_pm_addr);
    end
    for (int k = 4; k >= 1; k--) begin
      cycle(OP_RET, 16'h0000, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (o_pm_addr !== 16'(k * 256 + 1) || o_sp !== 3'(k - 1)) begin
        n_err++;
        $display("FAIL full_ret[%0d]: got pc=%h sp=%0d expected pc=%h sp=%0d",
                 k, o_pm_addr, o_sp, 16'(k * 256 + 1), k - 1);
      end
    end
`endif
  endtask

  task automatic test_stall();
    logic [15:0] held;
    cycle(OP_JMP, 16'h0123, 1'b0, 1'b0, 1'b0);
    held = m_pc;
    for (int i = 0; i < 3; i++) begin
      cycle(OP_JMP, 16'h0555, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (o_pm_addr !== held) begin
        n_err++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, o_pm_addr, held);
      end
    end
    cycle(OP_JMP, 16'h0555, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_pm_addr !== 16'h0555) begin
      n_err++; $display("FAIL stall_release: got %h expected 0555", o_pm_addr);
    end
  endtask

  task automatic test_wrap();
    cycle(OP_JMP, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    cycle(OP_NEXT, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_pm_addr !== 16'h0000) begin
      n_err++; $display("FAIL wrap_next: got %h expected 0000", o_pm_addr);
    end
    cycle(OP_JMP, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    cycle(OP_CALL, 16'h0777, 1'b0, 1'b0, 1'b0);
    cycle(OP_RET, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_pm_addr !== 16'h0000) begin
      n_err++; $display("FAIL wrap_call: got %h expected 0000", o_pm_addr);
    end
  endtask

  task automatic test_halt_reset();
    cycle(OP_JMP, 16'h0070, 1'b0, 1'b0, 1'b0);
    cycle(OP_CALL, 16'h0080, 1'b0, 1'b0, 1'b0);
    cycle(OP_HALT, 16'h0000, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (o_halted !== 1'b1 || o_pm_addr !== 16'h0080) begin
      n_err++; $display("FAIL halt_enter: got h=%b pc=%h expected h=1 pc=0080", o_halted, o_pm_addr);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(OP_NEXT, 16'h0000, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (o_pm_addr !== 16'h0080 || o_sp !== 3'd1 || o_halted !== 1'b1) begin
        n_err++;
        $display("FAIL halt_frozen[%0d]: got pc=%h sp=%0d h=%b expected pc=0080 sp=1 h=1",
                 i, o_pm_addr, o_sp, o_halted);
      end
    end
    #2 i_reset_ext = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (o_pm_addr !== 16'h0000 || o_halted !== 1'b0 || o_sp !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset: got pc=%h h=%b sp=%0d expected pc=0000 h=0 sp=0",
               o_pm_addr, o_halted, o_sp);
    end
    @(negedge i_clk);
    i_reset_ext = 1'b1;
    // Reset arriving while a CALL is being presented must leave no pushed entry.
    cycle(OP_JMP, 16'h0060, 1'b0, 1'b0, 1'b0);
    i_op = OP_CALL;
    i_target = 16'h0090;
    #2 i_reset_ext = 1'b0;
    #1;
    model_reset();
    @(negedge i_clk);
    n_cmp++;
    if (o_pm_addr !== 16'h0000 || o_sp !== 3'd0) begin
      n_err++; $display("FAIL reset_mid_call: got pc=%h sp=%0d expected pc=0000 sp=0",
                        o_pm_addr, o_sp);
    end
    i_op = OP_NEXT;
    i_reset_ext = 1'b1;
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [15:0] tgt;
    logic        stall;
    int          frozen;
    frozen = 0;
    for (int i = 0; i < 600; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == OP_HALT && $urandom_range(0, 9) != 0) op = OP_NEXT;
      if (!CHECK && op == OP_RET && m_stack.size() == 0) op = OP_NEXT;
      tgt = (i % 5 == 0) ? 16'hFFFF : 16'($urandom);
      stall = ($urandom_range(0, 7) == 0);
      cycle(op, tgt, 1'($urandom), 1'($urandom), stall);
      n_cmp++;
      if (o_pm_addr !== m_pc || o_sp !== 3'(m_stack.size())) begin
        n_err++;
        $display("FAIL rand_pc_sp[%0d]: got pc=%h sp=%0d expected pc=%h sp=%0d",
                 i, o_pm_addr, o_sp, m_pc, m_stack.size());
      end
      n_cmp++;
      if (o_halted !== m_halted || o_fault !== m_fault) begin
        n_err++;
        $display("FAIL rand_state[%0d]: got h=%b f=%b expected h=%b f=%b",
                 i, o_halted, o_fault, m_halted, m_fault);
      end
      if (m_halted || m_fault) frozen++;
      if (frozen >= 3) begin
        frozen = 0;
        apply_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_next();
    test_cond_branch();
    test_call_ret();
    apply_reset();
    test_stack_full();
    apply_reset();
    test_stall();
    test_wrap();
    test_halt_reset();
    apply_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
